rpn_display_driver: RTL and testbench
=====================================

Name: rpn_display_driver

Overview:
- Consumes the calculator's 16-bit ToDisplay word and 3-bit Status, and drives the board's 8-digit multiplexed 7-segment display.
- Decimal mode: a sequential double-dabble converter turns the word into 5 BCD digits, with leading-zero blanking.
- Hex mode: shows 4 hex nibbles.
- Digit 7 always shows Status.

Parameters:
- REFRESH_DIV, 100000, clock cycles each digit stays lit (1 kHz digit rate at 100 MHz); minimum 2.

Ports:
- clk  in  1  system clock; one clock domain.
- reset  in  1  asynchronous, active-low (asserted at 0); clears all state.
- Value  in  16  word to display (calculator ToDisplay).
- HexMode  in  1  1 = hexadecimal, 0 = unsigned decimal.
- Status  in  3  calculator FSM status, shown on digit 7.
- Segments  out  7  active-low cathodes, bit0=a … bit6=g.
- Anodes  out  8  active-low digit enables, bit i = digit i (digit 0 rightmost).
- DP  out  1  decimal point, active-low; constant 1 (off).
- Busy  out  1  high while a conversion is in progress.

Behaviour:
- Reset values: Segments=7'h7F, Anodes=8'hFF, DP=1, Busy=0, prescaler=0, digit index=0.
  - Display register holds decimal "0" (digit 0 = 0, all others blank).
  - last_value=0, last_mode=0, FSM in IDLE.
- Outputs are registered. The first clock edge after reset release lights digit 0.
- Update FSM states: IDLE, LOAD, SHIFT, DONE.
  - IDLE: if Value != last_value or HexMode != last_mode, go to LOAD. Otherwise stay.
  - LOAD (1 cycle): capture Value and HexMode into a working register and into last_value/last_mode. Clear the BCD accumulator and iteration counter. Go to DONE if HexMode, else SHIFT.
  - SHIFT (16 cycles, counter 0..15): add 3 to each BCD nibble ≥5, then shift {bcd,bin} left by 1. Go to DONE after iteration 15.
  - DONE (1 cycle): write the display register, then go to IDLE.
  - Busy=1 in LOAD and SHIFT only.
- Latency from the first cycle Value differs (seen in IDLE) to the display register updating:
  - decimal: 19 edges (detect, LOAD, 16×SHIFT, DONE);
  - hex: 3 edges.
- Value/HexMode changes while not in IDLE are not captured. The comparison in the next IDLE re-triggers, so the final displayed value always tracks the latest input.
- Display register contents:
  - Decimal: digits 4..0 = BCD ten-thousands..units. Leading zeros are blanked from digit 4 down to digit 1; digit 0 is never blanked. Digits 6..5 are blank.
  - Hex: digits 3..0 = nibbles 15:12..3:0, no blanking. Digits 6..4 are blank.
  - Digit 7 = Status as 0–7, updated live (not through the FSM).
- Scan:
  - Prescaler counts 0..REFRESH_DIV-1. On terminal count it wraps to 0 and the digit index increments mod 8 (7→0).
  - Anodes = ~(1<<index).
  - Segments = glyph(digit[index]); a blank digit gives 7'h7F.
- Glyphs (active-low, g..a):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110
- Reset asserted mid-conversion aborts immediately to reset values.
  - After release, reset conditions re-trigger a conversion if Value≠0 or HexMode=1.
- Value=16'hFFFF decimal → 65535; the 20-bit BCD accumulator never overflows.

Decomposition:
- Shared package rpn_display_pkg:
  - typedef enum for IDLE/LOAD/SHIFT/DONE;
  - 7-bit glyph constants and SEG_BLANK=7'h7F;
  - 5-bit digit code type (bit4=blank);
  - glyph lookup function.
- One sub-module, bin16_to_bcd: the double-dabble sequencer.
  - Interface: start/busy/done handshake, 16-bit in, 20-bit BCD out.
  - Owns SHIFT iteration.
  - The top keeps the compare/capture logic, the display register and the scan.

Test Plan (REFRESH_DIV=4 in simulation):
- Reset low 3 cycles, Value=0, HexMode=0, Status=0, then release. Required: Anodes sequence FE,FD,…,7F every 4 cycles; digit 0 Segments=1000000; digits 1–6 7F; digit 7 = glyph 0; Busy stays 0.
- Value=12345, decimal. Required: Busy high exactly 17 cycles; 19 edges after the change, digits 4..0 show 1,2,3,4,5; digits 6..5 blank.
- Value=16'hFFFF decimal → 6,5,5,3,5 on digits 4..0. Then HexMode=1 → F,F,F,F on digits 3..0 after 3 edges, with Busy high 1 cycle.
- Value=7 decimal, then 16'h0070 hex. Required: decimal shows only digit 0=7; hex shows 0,0,7,0 (no blanking).
- Value=100, changed to 200 at the 5th SHIFT cycle. Required: display shows 100 at DONE, then a second conversion starts and shows 200; no intermediate garbage.
- Reset asserted during SHIFT with Value=500. Required: outputs go to reset values asynchronously; after release, conversion restarts and 500 appears 19 edges later. Status=5 shows glyph 5 on digit 7 throughout.

Source files
------------

// File: rtl/rpn_display_pkg.sv
// Shared types and glyph table for the RPN calculator display driver.
// Digit codes carry a blank flag in bit 4 so the scan can darken a digit without a separate mask.
package rpn_display_pkg;

   typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} upd_state_t;

   typedef logic [4:0] digit_t;

   localparam digit_t     DIGIT_BLANK = 5'h10;
   localparam logic [6:0] SEG_BLANK   = 7'h7F;

   // Active-low cathodes, bit order g..a
   localparam logic [6:0] GLYPH_0 = 7'b1000000;
   localparam logic [6:0] GLYPH_1 = 7'b1111001;
   localparam logic [6:0] GLYPH_2 = 7'b0100100;
   localparam logic [6:0] GLYPH_3 = 7'b0110000;
   localparam logic [6:0] GLYPH_4 = 7'b0011001;
   localparam logic [6:0] GLYPH_5 = 7'b0010010;
   localparam logic [6:0] GLYPH_6 = 7'b0000010;
   localparam logic [6:0] GLYPH_7 = 7'b1111000;
   localparam logic [6:0] GLYPH_8 = 7'b0000000;
   localparam logic [6:0] GLYPH_9 = 7'b0010000;
   localparam logic [6:0] GLYPH_A = 7'b0001000;
   localparam logic [6:0] GLYPH_B = 7'b0000011;
   localparam logic [6:0] GLYPH_C = 7'b1000110;
   localparam logic [6:0] GLYPH_D = 7'b0100001;
   localparam logic [6:0] GLYPH_E = 7'b0000110;
   localparam logic [6:0] GLYPH_F = 7'b0001110;

   function automatic logic [6:0] glyph(input digit_t d);
      logic [6:0] seg;
      seg = SEG_BLANK;
      if (!d[4]) begin
         case (d[3:0])
            4'h0: seg = GLYPH_0;
            4'h1: seg = GLYPH_1;
            4'h2: seg = GLYPH_2;
            4'h3: seg = GLYPH_3;
            4'h4: seg = GLYPH_4;
            4'h5: seg = GLYPH_5;
            4'h6: seg = GLYPH_6;
            4'h7: seg = GLYPH_7;
            4'h8: seg = GLYPH_8;
            4'h9: seg = GLYPH_9;
            4'hA: seg = GLYPH_A;
            4'hB: seg = GLYPH_B;
            4'hC: seg = GLYPH_C;
            4'hD: seg = GLYPH_D;
            4'hE: seg = GLYPH_E;
            4'hF: seg = GLYPH_F;
         endcase
      end
      return seg;
   endfunction

endpackage

// File: rtl/rpn_display_driver_bin16_to_bcd.sv
// Sequential double-dabble: 16 shift iterations after start, BCD valid in the cycle after done.
// The 20-bit accumulator holds up to 65535 with room to spare in the top nibble.
module bin16_to_bcd
   import rpn_display_pkg::*;
(
   input  logic        clk_sys,
   input  logic        rst_b,
   input  logic        start,
   input  logic [15:0] bin,
   output logic        busy,
   output logic        done,
   output logic [19:0] bcd
);

   logic [15:0] work;
   logic [3:0]  iter;
   logic        running;
   logic [19:0] bcd_adj;

   always_comb begin
      bcd_adj = bcd;
      for (int i = 0; i < 5; i++) begin
         if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end
   end

   always_ff @(posedge clk_sys or negedge rst_b) begin
      if (!rst_b) begin
         work    <= '0;
         bcd     <= '0;
         iter    <= '0;
         running <= 1'b0;
      end else if (start) begin
         work    <= bin;
         bcd     <= '0;
         iter    <= '0;
         running <= 1'b1;
      end else if (running) begin
         {bcd, work} <= {bcd_adj, work} << 1;
         iter        <= iter + 4'd1;
         if (iter == 4'd15) running <= 1'b0;
      end
   end

   assign busy = running;
   // Asserted during the last iteration so the caller can step to DONE on the same edge
   assign done = running && (iter == 4'd15);

endmodule

// File: rtl/rpn_display_driver.sv
// 8-digit multiplexed 7-segment driver for the RPN calculator: decimal/hex value on
// digits 4..0, live status on digit 7, display register refreshed by a small update FSM.
//
// state | meaning
// IDLE  | display current; waiting for Value/HexMode to differ from last capture
// LOAD  | capture inputs, kick off BCD conversion in decimal mode
// SHIFT | double-dabble iterations running in bin16_to_bcd
// DONE  | write display register
module rpn_display_driver
   import rpn_display_pkg::*;
#(
   parameter int REFRESH_DIV = 100000
)(
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] Value,
   input  logic        HexMode,
   input  logic [2:0]  Status,
   output logic [6:0]  Segments,
   output logic [7:0]  Anodes,
   output logic        DP,
   output logic        Busy
);

   localparam int               PRE_W   = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(REFRESH_DIV - 1);

   upd_state_t  state, state_nxt;
   logic [15:0] last_value, work_value;
   logic        last_mode, work_hex;
   logic        conv_start, conv_busy, conv_done;
   logic [19:0] bcd;
   digit_t      disp      [7];
   digit_t      disp_nxt  [7];
   digit_t      scan_digits [8];
   logic        lead;
   logic [PRE_W-1:0] pre;
   logic [2:0]  idx;

   bin16_to_bcd u_bcd (
      .clk_sys (clk),
      .rst_b   (reset),
      .start   (conv_start),
      .bin     (Value),
      .busy    (conv_busy),
      .done    (conv_done),
      .bcd     (bcd)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      conv_start = 1'b0;
      case (state)
         IDLE:  if (Value != last_value || HexMode != last_mode) state_nxt = LOAD;
         LOAD: begin
            conv_start = !HexMode;
            state_nxt  = HexMode ? DONE : SHIFT;
         end
         SHIFT: if (conv_done) state_nxt = DONE;
         DONE:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign Busy = (state == LOAD) || conv_busy;
   assign DP   = 1'b1;

   // Blanking runs from digit 4 downward and stops at the first non-zero digit
   always_comb begin
      lead = 1'b1;
      for (int i = 0; i < 7; i++) disp_nxt[i] = DIGIT_BLANK;
      if (work_hex) begin
         for (int i = 0; i < 4; i++) disp_nxt[i] = {1'b0, work_value[4*i +: 4]};
      end else begin
         for (int i = 4; i >= 1; i--) begin
            lead        = lead && (bcd[4*i +: 4] == 4'd0);
            disp_nxt[i] = lead ? DIGIT_BLANK : {1'b0, bcd[4*i +: 4]};
         end
         disp_nxt[0] = {1'b0, bcd[3:0]};
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         last_value <= '0;
         last_mode  <= 1'b0;
         work_value <= '0;
         work_hex   <= 1'b0;
         disp[0]    <= 5'h00;
         for (int i = 1; i < 7; i++) disp[i] <= DIGIT_BLANK;
      end else begin
         if (state == LOAD) begin
            last_value <= Value;
            last_mode  <= HexMode;
            work_value <= Value;
            work_hex   <= HexMode;
         end
         if (state == DONE) begin
            for (int i = 0; i < 7; i++) disp[i] <= disp_nxt[i];
         end
      end
   end

   always_comb begin
      for (int i = 0; i < 7; i++) scan_digits[i] = disp[i];
      scan_digits[7] = {2'b00, Status};
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pre      <= '0;
         idx      <= '0;
         Segments <= SEG_BLANK;
         Anodes   <= 8'hFF;
      end else begin
         if (pre == PRE_MAX) begin
            pre <= '0;
            idx <= idx + 3'd1;
         end else begin
            pre <= pre + 1'b1;
         end
         Anodes   <= ~(8'b1 << idx);
         Segments <= glyph(scan_digits[idx]);
      end
   end

endmodule

// File: tb/tb_rpn_display_driver.sv
// Directed bench for rpn_display_driver with a 4-cycle digit dwell.
module tb_rpn_display_driver;

   localparam logic [6:0] G0 = 7'h40, G1 = 7'h79, G2 = 7'h24, G3 = 7'h30;
   localparam logic [6:0] G4 = 7'h19, G5 = 7'h12, G6 = 7'h02, G7 = 7'h78;
   localparam logic [6:0] GF = 7'h0E, BL = 7'h7F;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] Value;
   logic        HexMode;
   logic [2:0]  Status;
   logic [6:0]  Segments;
   logic [7:0]  Anodes;
   logic        DP;
   logic        Busy;

   int n_cmp = 0;
   int n_bad = 0;

   rpn_display_driver #(.REFRESH_DIV(4)) dut (
      .clk      (clk),
      .reset    (reset),
      .Value    (Value),
      .HexMode  (HexMode),
      .Status   (Status),
      .Segments (Segments),
      .Anodes   (Anodes),
      .DP       (DP),
      .Busy     (Busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // exp packs digit 7 in the top 7 bits down to digit 0 in the bottom 7 bits
   task automatic check_display(input string tag, input logic [55:0] exp);
      for (int d = 0; d < 8; d++) begin
         logic [7:0] tgt;
         logic       found;
         tgt   = ~(8'd1 << d);
         found = 1'b0;
         for (int k = 0; k < 80 && !found; k++) begin
            if (Anodes === tgt) found = 1'b1;
            else @(negedge clk);
         end
         check($sformatf("%s_d%0d_found", tag, d), {31'd0, found}, 32'd1);
         if (found) check($sformatf("%s_d%0d_seg", tag, d), {25'd0, Segments}, {25'd0, exp[7*d +: 7]});
      end
   endtask

   // Applies inputs at a falling edge, counts Busy samples, and checks the display
   // register entry d_idx one edge before and exactly at the expected latency.
   task automatic conv(input string tag, input logic [15:0] v, input logic h,
                       input int exp_busy, input int lat, input int d_idx,
                       input logic [4:0] d_old, input logic [4:0] d_new);
      int bc;
      bc = 0;
      Value   = v;
      HexMode = h;
      for (int k = 1; k <= 24; k++) begin
         @(negedge clk);
         if (Busy === 1'b1) bc++;
         if (k == lat - 1) check($sformatf("%s_before", tag), {27'd0, dut.disp[d_idx]}, {27'd0, d_old});
         if (k == lat)     check($sformatf("%s_after", tag),  {27'd0, dut.disp[d_idx]}, {27'd0, d_new});
      end
      check($sformatf("%s_busy_cycles", tag), bc, exp_busy);
   endtask

   initial begin
      int bc;
      reset   = 1'b0;
      Value   = 16'd0;
      HexMode = 1'b0;
      Status  = 3'd0;

      repeat (3) @(negedge clk);
      check("rst_segments", {25'd0, Segments}, 32'h7F);
      check("rst_anodes",   {24'd0, Anodes},   32'hFF);
      check("rst_dp",       {31'd0, DP},       32'd1);
      check("rst_busy",     {31'd0, Busy},     32'd0);

      // Scan from reset: one digit per 4 cycles, decimal "0" with blanks, status 0 on digit 7
      reset = 1'b1;
      for (int i = 0; i < 8; i++) begin
         logic [6:0] es;
         @(negedge clk);
         es = (i == 0 || i == 7) ? G0 : BL;
         check($sformatf("scan_anode%0d", i), {24'd0, Anodes}, {24'd0, ~(8'd1 << i)});
         check($sformatf("scan_seg%0d", i),   {25'd0, Segments}, {25'd0, es});
         check($sformatf("scan_busy%0d", i),  {31'd0, Busy}, 32'd0);
         repeat (3) @(negedge clk);
      end

      conv("dec12345", 16'd12345, 1'b0, 17, 19, 0, 5'h00, 5'h05);
      check_display("disp12345", {G0, BL, BL, G1, G2, G3, G4, G5});

      conv("decFFFF", 16'hFFFF, 1'b0, 17, 19, 4, 5'h01, 5'h06);
      check_display("disp65535", {G0, BL, BL, G6, G5, G5, G3, G5});

      conv("hexFFFF", 16'hFFFF, 1'b1, 1, 3, 3, 5'h05, 5'h0F);
      check_display("dispFFFFh", {G0, BL, BL, BL, GF, GF, GF, GF});

      conv("dec7", 16'd7, 1'b0, 17, 19, 0, 5'h0F, 5'h07);
      check_display("disp7", {G0, BL, BL, BL, BL, BL, BL, G7});

      conv("hex0070", 16'h0070, 1'b1, 1, 3, 1, 5'h10, 5'h07);
      check_display("disp0070h", {G0, BL, BL, BL, G0, G0, G7, G0});

      // 100 captured, then 200 arrives mid-conversion and is picked up by a second pass
      bc = 0;
      Value   = 16'd100;
      HexMode = 1'b0;
      for (int k = 1; k <= 45; k++) begin
         @(negedge clk);
         if (Busy === 1'b1) bc++;
         if (k == 6) Value = 16'd200;
         if (k == 18) check("retrig_pre100",  {27'd0, dut.disp[2]}, 32'h00);
         if (k == 19) check("retrig_shows100", {27'd0, dut.disp[2]}, 32'h01);
         if (k == 28) check("retrig_hold100",  {27'd0, dut.disp[2]}, 32'h01);
         if (k == 37) check("retrig_pre200",  {27'd0, dut.disp[2]}, 32'h01);
         if (k == 38) check("retrig_shows200", {27'd0, dut.disp[2]}, 32'h02);
      end
      check("retrig_busy_cycles", bc, 34);
      check_display("disp200", {G0, BL, BL, BL, BL, G2, G0, G0});

      // Reset in the middle of SHIFT, with status 5 shown live
      Status  = 3'd5;
      Value   = 16'd500;
      repeat (6) @(negedge clk);
      check("mid_busy", {31'd0, Busy}, 32'd1);
      #2 reset = 1'b0;
      #1;
      check("async_segments", {25'd0, Segments}, 32'h7F);
      check("async_anodes",   {24'd0, Anodes},   32'hFF);
      check("async_busy",     {31'd0, Busy},     32'd0);
      check("async_dp",       {31'd0, DP},       32'd1);
      check("async_disp0",    {27'd0, dut.disp[0]}, 32'h00);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      conv("post_rst500", 16'd500, 1'b0, 17, 19, 2, 5'h10, 5'h05);
      check_display("disp500", {G5, BL, BL, BL, BL, G5, G0, G0});

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

endmodule
